// File: rtl/aes_pkg.sv
// Shared constants and types for the ciphertext serializer.
// The beat count and holding-register width depend on whether the shares are
// recombined at capture. Set the build macro CT_UNMASK_EN to enable that
// (8 beats, 128-bit holding register). Leave it undefined for the default
// masked datapath (16 beats, 256-bit holding register).
package aes_pkg;

  localparam int NBYTES  = 16;
  localparam int SHARE_W = 8;
  localparam int BEAT_W  = 2 * SHARE_W;
  localparam int STATE_W = 2 * NBYTES * SHARE_W;
  localparam int CNT_W   = 4;

`ifdef CT_UNMASK_EN
  localparam int CT_BEATS = NBYTES / 2;
  localparam int HOLD_W   = NBYTES * SHARE_W;
`else
  localparam int CT_BEATS = NBYTES;
  localparam int HOLD_W   = STATE_W;
`endif

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage

// File: rtl/ct_beat_counter.sv
// Beat index for the ciphertext stream.
// Ports:
//   clk, rst_n : clock and async active-low reset
//   en         : advance by one (one accepted beat)
//   cnt        : current beat index
//   tc         : cnt is on the final beat of the block
// When enabled on the terminal count, the counter returns to 0. No other path wraps it.
module ct_beat_counter
  import aes_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CT_BEATS - 1);

  assign tc = (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ct_serializer.sv
// Captures the final two-share AES state in one cycle and streams it out one
// beat per valid/ready handshake. The holding register is zeroized after the
// last beat is accepted.
// Build macro: CT_UNMASK_EN recombines the shares at capture and sends 8 beats
// of {u(2j), u(2j+1)}. When it is undefined, 16 beats of {share1 byte i, share0 byte i} are sent.
// Ports:
//   clk, rst_n : clock and async active-low reset
//   load       : one-cycle capture request for state_in
//   state_in   : [255:128] share1 b0..b15, [127:0] share0 b0..b15, MSB-first
//   out_data   : beat payload
//   out_valid  : payload valid
//   out_ready  : sink accepts the beat
//   out_last   : final beat of the block
//   busy       : block held and not yet drained
//   load_drop  : pulse, a load was refused on the previous cycle
//
// state | meaning
// IDLE  | nothing held, holding register zero, out_valid low
// SEND  | block held, presenting beat cnt
module ct_serializer
  import aes_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [STATE_W-1:0] state_in,
  output logic [BEAT_W-1:0]  out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last,
  output logic               busy,
  output logic               load_drop
);

  state_t             state, state_nxt;
  logic [HOLD_W-1:0]  hold;
  logic [HOLD_W-1:0]  captured;
  logic [CNT_W-1:0]   cnt;
  logic               tc;
  logic               handshake;
  logic               last_hs;
  logic               load_acc;

  assign out_valid = (state == SEND);
  assign busy      = out_valid;
  assign out_last  = out_valid && tc;
  assign handshake = out_valid && out_ready;
  assign last_hs   = handshake && tc;
  // A reload is taken on the final handshake, so back-to-back blocks have no bubble.
  assign load_acc  = load && ((state == IDLE) || last_hs);

  ct_beat_counter u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (handshake),
    .cnt   (cnt),
    .tc    (tc)
  );

`ifdef CT_UNMASK_EN
  logic [BEAT_W-1:0] words [CT_BEATS];

  for (genvar k = 0; k < NBYTES; k++) begin : g_cap
    assign captured[HOLD_W-1-k*SHARE_W -: SHARE_W] =
      state_in[STATE_W-1-k*SHARE_W -: SHARE_W] ^ state_in[HOLD_W-1-k*SHARE_W -: SHARE_W];
  end

  for (genvar j = 0; j < CT_BEATS; j++) begin : g_words
    assign words[j] = hold[HOLD_W-1-j*BEAT_W -: BEAT_W];
  end

  assign out_data = words[cnt[2:0]];
`else
  logic [SHARE_W-1:0] sh1 [NBYTES];
  logic [SHARE_W-1:0] sh0 [NBYTES];

  assign captured = state_in;

  for (genvar i = 0; i < NBYTES; i++) begin : g_bytes
    assign sh1[i] = hold[STATE_W-1-i*SHARE_W -: SHARE_W];
    assign sh0[i] = hold[STATE_W/2-1-i*SHARE_W -: SHARE_W];
  end

  assign out_data = {sh1[cnt], sh0[cnt]};
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load) state_nxt = SEND;
      SEND:    if (last_hs) state_nxt = load ? SEND : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      hold      <= '0;
      load_drop <= 1'b0;
    end else begin
      state     <= state_nxt;
      load_drop <= load && !load_acc;
      if (load_acc) begin
        hold <= captured;
      end else if (last_hs) begin
        hold <= '0;
      end
    end
  end

endmodule
